// File: rtl/cpu_pkg.sv
// Shared CPU front-end constants.
//   OPC_W            width of the opcode field, which sits in the top bits of an instruction
//   HLT_OPCODE_DFLT  default opcode that stops instruction fetch
//   ADDR_W_DFLT      default PC / imem address width
//   INSTR_W_DFLT     default instruction width
//   entry_w()        width of one prefetch entry {pc, instr}
package cpu_pkg;

    localparam int unsigned     OPC_W           = 4;
    localparam logic [OPC_W-1:0] HLT_OPCODE_DFLT = 4'hF;
    localparam int unsigned     ADDR_W_DFLT     = 16;
    localparam int unsigned     INSTR_W_DFLT    = 16;

    // Prefetch entries are stored as {pc, instr}.
    function automatic int unsigned entry_w(input int unsigned addr_w,
                                            input int unsigned instr_w);
        return addr_w + instr_w;
    endfunction

endpackage

// File: rtl/if_queue.sv
// Synchronous FIFO that holds prefetched {pc, instr} entries.
//   clk, rst   clock and synchronous active-high reset
//   push       write push_data at the tail
//   push_data  entry to write
//   pop        drop the head entry
//   flush      empty the queue. A push in the same cycle is dropped.
//   head_data  oldest entry. It is only meaningful when count != 0.
//   count      number of stored entries (0..DEPTH)
// The caller never pushes when the queue is full and never pops when it is empty.
module if_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    // Pointer and occupancy update. DEPTH is a power of 2, so the pointers wrap naturally.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset. Its contents are only observed through count.
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q] <= push_data;
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/instr_fetch_queue.sv
// Prefetching fetch stage.
// It issues reads to a 1-cycle-latency imem, queues the returned {pc, instr} entries
// and presents the queue head to decode. It supports branch redirect with flush,
// a post-reset arming window for branches, and a halt opcode that freezes fetch.
//   clk, rst     clock and synchronous active-high reset
//   imem_rd_en   read request this cycle, driven at imem_addr
//   imem_rdata   data for the request issued in the previous cycle
//   dec_valid    queue head valid. The head is presented as dec_instr, dec_pc and dec_pc_next.
//   dec_ready    decode accepts the head
//   branch       redirect request to branch_addr (ignored until armed)
//   hlt          a halt instruction is at the head
module instr_fetch_queue
    import cpu_pkg::*;
#(
    parameter int unsigned       ADDR_W     = ADDR_W_DFLT,
    parameter int unsigned       INSTR_W    = INSTR_W_DFLT,
    parameter int unsigned       DEPTH      = 4,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter logic [OPC_W-1:0]  HLT_OPCODE = HLT_OPCODE_DFLT,
    parameter int unsigned       BR_ARM     = 3
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_rd_en,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               dec_valid,
    input  logic               dec_ready,
    output logic [INSTR_W-1:0] dec_instr,
    output logic [ADDR_W-1:0]  dec_pc,
    output logic [ADDR_W-1:0]  dec_pc_next,
    input  logic               branch,
    input  logic [ADDR_W-1:0]  branch_addr,
    output logic               hlt
);

    localparam int unsigned ENTRY_W = entry_w(ADDR_W, INSTR_W);
    localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
    localparam int unsigned ARM_W   = (BR_ARM > 0) ? $clog2(BR_ARM + 1) : 1;

    logic [ADDR_W-1:0]  fetch_pc_q,  fetch_pc_d;
    logic [ADDR_W-1:0]  infl_pc_q,   infl_pc_d;
    logic               inflight_q,  inflight_d;
    logic               halt_seen_q, halt_seen_d;
    logic [ARM_W-1:0]   arm_cnt_q,   arm_cnt_d;

    logic               armed;
    logic               redirect;
    logic               issue;
    logic               push;
    logic               pop;
    logic               halt_hit;
    logic               head_halt;
    logic [CNT_W:0]     credit_used;
    logic [CNT_W-1:0]   q_count;
    logic [ENTRY_W-1:0] q_head;

    assign armed    = (arm_cnt_q == ARM_W'(BR_ARM));
    assign redirect = branch & armed;

    // A response is killed when a redirect or reset happens in the cycle it arrives.
    assign push     = inflight_q & ~redirect & ~rst;
    // Block the issue in the cycle a halt returns. Otherwise the next sequential address would still go out.
    assign halt_hit = push & (imem_rdata[INSTR_W-1 -: OPC_W] == HLT_OPCODE);

    // Queued entries plus the outstanding request must never exceed DEPTH.
    assign credit_used = {1'b0, q_count} + (CNT_W + 1)'(inflight_q);
    assign issue = ~rst & ~redirect & ~halt_seen_q & ~halt_hit
                 & (credit_used < (CNT_W + 1)'(DEPTH));

    assign dec_valid = (q_count != '0);
    assign head_halt = dec_valid & (q_head[INSTR_W-1 -: OPC_W] == HLT_OPCODE);
    assign hlt       = head_halt & ~redirect;
    // A halt entry stays at the head. A redirect flushes the queue instead of popping it.
    assign pop       = dec_valid & dec_ready & ~head_halt & ~redirect;

    assign imem_rd_en  = issue;
    assign imem_addr   = fetch_pc_q;
    assign dec_pc      = dec_valid ? q_head[ENTRY_W-1 -: ADDR_W] : '0;
    assign dec_instr   = dec_valid ? q_head[INSTR_W-1:0] : '0;
    assign dec_pc_next = dec_pc + ADDR_W'(1);

    // Fetch PC, outstanding request, halt latch and arm counter.
    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        infl_pc_d   = infl_pc_q;
        inflight_d  = issue;
        halt_seen_d = halt_seen_q | halt_hit;
        arm_cnt_d   = armed ? arm_cnt_q : arm_cnt_q + ARM_W'(1);
        if (issue) begin
            fetch_pc_d = fetch_pc_q + ADDR_W'(1);
            infl_pc_d  = fetch_pc_q;
        end
        if (redirect) begin
            fetch_pc_d  = branch_addr;
            halt_seen_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q  <= RESET_PC;
            infl_pc_q   <= '0;
            inflight_q  <= 1'b0;
            halt_seen_q <= 1'b0;
            arm_cnt_q   <= '0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            infl_pc_q   <= infl_pc_d;
            inflight_q  <= inflight_d;
            halt_seen_q <= halt_seen_d;
            arm_cnt_q   <= arm_cnt_d;
        end
    end

    if_queue #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({infl_pc_q, imem_rdata}),
        .pop       (pop),
        .flush     (redirect),
        .head_data (q_head),
        .count     (q_count)
    );

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue. It uses directed scenarios plus a randomized run
// that is checked against a transaction-level queue model.
module tb_instr_fetch_queue;

    localparam int unsigned       ADDR_W   = 16;
    localparam int unsigned       INSTR_W  = 16;
    localparam int unsigned       DEPTH    = 4;
    localparam int unsigned       BR_ARM   = 3;
    localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               imem_rd_en;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata = '0;
    logic               dec_valid;
    logic               dec_ready = 1'b1;
    logic [INSTR_W-1:0] dec_instr;
    logic [ADDR_W-1:0]  dec_pc;
    logic [ADDR_W-1:0]  dec_pc_next;
    logic               branch = 1'b0;
    logic [ADDR_W-1:0]  branch_addr = '0;
    logic               hlt;

    logic [INSTR_W-1:0] mem [0:65535];
    int unsigned        vectors = 0;
    int unsigned        miscompares = 0;

    instr_fetch_queue #(
        .ADDR_W   (ADDR_W),
        .INSTR_W  (INSTR_W),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC),
        .BR_ARM   (BR_ARM)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_rd_en  (imem_rd_en),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .dec_valid   (dec_valid),
        .dec_ready   (dec_ready),
        .dec_instr   (dec_instr),
        .dec_pc      (dec_pc),
        .dec_pc_next (dec_pc_next),
        .branch      (branch),
        .branch_addr (branch_addr),
        .hlt         (hlt)
    );

    always #5 clk = ~clk;

    // 1-cycle imem. Cycles without a request return garbage.
    always @(posedge clk) begin
        imem_rdata <= imem_rd_en ? mem[imem_addr] : INSTR_W'($urandom);
    end

    task automatic apply_reset();
        rst = 1'b1;
        branch = 1'b0;
        dec_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        branch = 1'b1;
        branch_addr = 16'h0040;
        @(negedge clk);
        @(negedge clk);
        #1;
        vectors++;
        if (dec_valid !== 1'b0 || hlt !== 1'b0 || imem_rd_en !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl got valid=%b hlt=%b rd_en=%b exp 0 0 0", dec_valid, hlt, imem_rd_en);
        end
        vectors++;
        if (imem_addr !== RESET_PC || dec_pc !== 16'h0 || dec_instr !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_data got addr=%h pc=%h instr=%h exp %h 0000 0000", imem_addr, dec_pc, dec_instr, RESET_PC);
        end
        @(negedge clk);
        branch = 1'b0;
    endtask

    task automatic test_stream();
        apply_reset();
        for (int k = 0; k < 12; k++) begin
            logic [ADDR_W-1:0] epc;
            epc = ADDR_W'(k - 2);
            #1;
            vectors++;
            if (imem_rd_en !== 1'b1 || imem_addr !== ADDR_W'(k)) begin
                miscompares++;
                $display("FAIL stream_issue cyc=%0d got en=%b addr=%h exp en=1 addr=%h", k, imem_rd_en, imem_addr, ADDR_W'(k));
            end
            vectors++;
            if (dec_valid !== (k >= 2)) begin
                miscompares++;
                $display("FAIL stream_valid cyc=%0d got %b exp %b", k, dec_valid, (k >= 2));
            end
            if (k >= 2) begin
                vectors++;
                if (dec_pc !== epc || dec_instr !== 16'h1000 + epc || dec_pc_next !== epc + 16'd1) begin
                    miscompares++;
                    $display("FAIL stream_head cyc=%0d got pc=%h instr=%h next=%h exp pc=%h instr=%h next=%h",
                             k, dec_pc, dec_instr, dec_pc_next, epc, 16'h1000 + epc, epc + 16'd1);
                end
            end
            @(negedge clk);
        end
    endtask

    // Decode stalls for cycles 3..12. Issue stops when the credits run out, then the stream resumes without gaps.
    task automatic test_backpressure();
        apply_reset();
        for (int k = 0; k < 25; k++) begin
            logic              exp_en;
            logic [ADDR_W-1:0] exp_addr;
            logic [ADDR_W-1:0] exp_pc;
            dec_ready = !(k >= 3 && k <= 12);
            exp_en    = (k <= 4) || (k >= 14);
            exp_addr  = (k <= 4) ? ADDR_W'(k) : ADDR_W'(k - 9);
            exp_pc    = (k == 2) ? 16'd0 : (k <= 13) ? 16'd1 : ADDR_W'(k - 12);
            #1;
            vectors++;
            if (imem_rd_en !== exp_en || (exp_en && imem_addr !== exp_addr)) begin
                miscompares++;
                $display("FAIL bp_issue cyc=%0d got en=%b addr=%h exp en=%b addr=%h", k, imem_rd_en, imem_addr, exp_en, exp_addr);
            end
            if (k >= 2) begin
                vectors++;
                if (dec_valid !== 1'b1 || dec_pc !== exp_pc || dec_instr !== mem[exp_pc]) begin
                    miscompares++;
                    $display("FAIL bp_head cyc=%0d got v=%b pc=%h instr=%h exp v=1 pc=%h instr=%h", k, dec_valid, dec_pc, dec_instr, exp_pc, mem[exp_pc]);
                end
            end
            @(negedge clk);
        end
        dec_ready = 1'b1;
    endtask

    // A branch before arming is ignored. An armed branch at head pc 5 flushes the queue and refetches from 0x0040.
    task automatic test_branch_arm();
        apply_reset();
        for (int k = 0; k < 12; k++) begin
            branch = (k == 1) || (k == 7);
            branch_addr = 16'h0040;
            #1;
            if (k == 1) begin
                vectors++;
                if (imem_rd_en !== 1'b1 || imem_addr !== 16'd1) begin
                    miscompares++;
                    $display("FAIL unarmed_issue got en=%b addr=%h exp en=1 addr=0001", imem_rd_en, imem_addr);
                end
            end
            if (k >= 2 && k <= 7) begin
                vectors++;
                if (dec_valid !== 1'b1 || dec_pc !== ADDR_W'(k - 2)) begin
                    miscompares++;
                    $display("FAIL unarmed_stream cyc=%0d got v=%b pc=%h exp v=1 pc=%h", k, dec_valid, dec_pc, ADDR_W'(k - 2));
                end
            end
            if (k == 7) begin
                vectors++;
                if (imem_rd_en !== 1'b0 || hlt !== 1'b0) begin
                    miscompares++;
                    $display("FAIL redirect_cycle got en=%b hlt=%b exp 0 0", imem_rd_en, hlt);
                end
            end
            if (k == 8) begin
                vectors++;
                if (imem_rd_en !== 1'b1 || imem_addr !== 16'h0040) begin
                    miscompares++;
                    $display("FAIL redirect_issue got en=%b addr=%h exp en=1 addr=0040", imem_rd_en, imem_addr);
                end
            end
            if (k == 8 || k == 9) begin
                vectors++;
                if (dec_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL flush_valid cyc=%0d got %b exp 0", k, dec_valid);
                end
            end
            if (k >= 10) begin
                vectors++;
                if (dec_valid !== 1'b1 || dec_pc !== ADDR_W'(16'h0040 + k - 10) || dec_instr !== ADDR_W'(16'h1040 + k - 10)) begin
                    miscompares++;
                    $display("FAIL redirect_head cyc=%0d got v=%b pc=%h instr=%h exp v=1 pc=%h instr=%h",
                             k, dec_valid, dec_pc, dec_instr, ADDR_W'(16'h0040 + k - 10), ADDR_W'(16'h1040 + k - 10));
                end
            end
            @(negedge clk);
        end
        branch = 1'b0;
    endtask

    // A halt at address 6 freezes fetch and holds hlt until a branch to 0x0010.
    task automatic test_halt();
        mem[6] = 16'hF000;
        apply_reset();
        for (int k = 0; k < 20; k++) begin
            branch = (k == 16);
            branch_addr = 16'h0010;
            #1;
            if (k < 16) begin
                vectors++;
                if (imem_rd_en === 1'b1 && imem_addr > ADDR_W'(6)) begin
                    miscompares++;
                    $display("FAIL halt_overfetch cyc=%0d got addr=%h issued exp no addr above 0006", k, imem_addr);
                end
            end
            if (k < 8) begin
                vectors++;
                if (hlt !== 1'b0) begin
                    miscompares++;
                    $display("FAIL hlt_early cyc=%0d got %b exp 0", k, hlt);
                end
            end
            if (k >= 8 && k < 16) begin
                vectors++;
                if (hlt !== 1'b1 || dec_valid !== 1'b1 || dec_pc !== 16'd6 || dec_instr !== 16'hF000) begin
                    miscompares++;
                    $display("FAIL hlt_hold cyc=%0d got hlt=%b v=%b pc=%h instr=%h exp 1 1 0006 f000", k, hlt, dec_valid, dec_pc, dec_instr);
                end
            end
            if (k == 16) begin
                vectors++;
                if (hlt !== 1'b0 || imem_rd_en !== 1'b0) begin
                    miscompares++;
                    $display("FAIL hlt_release got hlt=%b en=%b exp 0 0", hlt, imem_rd_en);
                end
            end
            if (k == 19) begin
                vectors++;
                if (dec_valid !== 1'b1 || dec_pc !== 16'h0010 || dec_instr !== 16'h1010 || hlt !== 1'b0) begin
                    miscompares++;
                    $display("FAIL hlt_refetch got v=%b pc=%h instr=%h hlt=%b exp 1 0010 1010 0", dec_valid, dec_pc, dec_instr, hlt);
                end
            end
            @(negedge clk);
        end
        branch = 1'b0;
        mem[6] = 16'h1006;
    endtask

    // PC wraps from 0xFFFF to 0x0000 in the issue path and on the decode side.
    task automatic test_wrap();
        logic [ADDR_W-1:0] exp_pc;
        apply_reset();
        for (int k = 0; k < 10; k++) begin
            branch = (k == 4);
            branch_addr = 16'hFFFE;
            #1;
            if (k >= 5 && k <= 7) begin
                exp_pc = ADDR_W'(16'hFFFE + (k - 5));
                vectors++;
                if (imem_rd_en !== 1'b1 || imem_addr !== exp_pc) begin
                    miscompares++;
                    $display("FAIL wrap_issue cyc=%0d got en=%b addr=%h exp en=1 addr=%h", k, imem_rd_en, imem_addr, exp_pc);
                end
            end
            if (k >= 7) begin
                exp_pc = ADDR_W'(16'hFFFE + (k - 7));
                vectors++;
                if (dec_valid !== 1'b1 || dec_pc !== exp_pc || dec_pc_next !== ADDR_W'(exp_pc + 16'd1)
                    || dec_instr !== ADDR_W'(16'h1000 + exp_pc)) begin
                    miscompares++;
                    $display("FAIL wrap_head cyc=%0d got v=%b pc=%h next=%h instr=%h exp v=1 pc=%h next=%h instr=%h",
                             k, dec_valid, dec_pc, dec_pc_next, dec_instr, exp_pc, ADDR_W'(exp_pc + 16'd1), ADDR_W'(16'h1000 + exp_pc));
                end
            end
            @(negedge clk);
        end
        branch = 1'b0;
    endtask

    // Reset while entries are queued and a response is in flight.
    task automatic test_reset_midflight();
        apply_reset();
        dec_ready = 1'b0;
        for (int k = 0; k < 4; k++) @(negedge clk);
        rst = 1'b1;
        #1;
        vectors++;
        if (imem_rd_en !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_issue got en=%b exp 0", imem_rd_en);
        end
        @(negedge clk);
        rst = 1'b0;
        dec_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            if (k == 0) begin
                vectors++;
                if (imem_rd_en !== 1'b1 || imem_addr !== RESET_PC) begin
                    miscompares++;
                    $display("FAIL midrst_first_issue got en=%b addr=%h exp en=1 addr=%h", imem_rd_en, imem_addr, RESET_PC);
                end
            end
            vectors++;
            if (dec_valid !== (k >= 2) || (k >= 2 && (dec_pc !== ADDR_W'(k - 2) || dec_instr !== ADDR_W'(16'h1000 + k - 2)))) begin
                miscompares++;
                $display("FAIL midrst_head cyc=%0d got v=%b pc=%h instr=%h exp v=%b pc=%h", k, dec_valid, dec_pc, dec_instr, (k >= 2), ADDR_W'(k - 2));
            end
            @(negedge clk);
        end
    endtask

    // Random stalls and branches, checked against an in-order queue of issued requests.
    // Each request becomes visible 2 cycles after it issues. An armed branch empties the queue.
    task automatic test_random();
        logic [ADDR_W-1:0] q_pc [$];
        int                q_t [$];
        logic [ADDR_W-1:0] nxt_issue;
        logic [ADDR_W-1:0] hpc;
        int                now;
        logic              redir;
        logic              exp_en;
        logic              exp_valid;
        apply_reset();
        nxt_issue = RESET_PC;
        now = 0;
        for (int n = 0; n < 600; n++) begin
            dec_ready   = ($urandom_range(0, 3) != 0);
            branch      = ($urandom_range(0, 15) == 0);
            branch_addr = ADDR_W'($urandom_range(0, 1023));
            redir     = branch && (now >= int'(BR_ARM));
            exp_en    = !redir && (q_pc.size() < int'(DEPTH));
            exp_valid = (q_t.size() > 0) && (q_t[0] + 2 <= now);
            hpc       = (q_pc.size() > 0) ? q_pc[0] : '0;
            #1;
            vectors++;
            if (imem_rd_en !== exp_en || (exp_en && imem_addr !== nxt_issue)) begin
                miscompares++;
                $display("FAIL rnd_issue cyc=%0d got en=%b addr=%h exp en=%b addr=%h", n, imem_rd_en, imem_addr, exp_en, nxt_issue);
            end
            vectors++;
            if (dec_valid !== exp_valid || hlt !== 1'b0) begin
                miscompares++;
                $display("FAIL rnd_valid cyc=%0d got v=%b hlt=%b exp v=%b hlt=0", n, dec_valid, hlt, exp_valid);
            end
            if (exp_valid) begin
                vectors++;
                if (dec_pc !== hpc || dec_instr !== mem[hpc] || dec_pc_next !== ADDR_W'(hpc + 16'd1)) begin
                    miscompares++;
                    $display("FAIL rnd_head cyc=%0d got pc=%h instr=%h next=%h exp pc=%h instr=%h next=%h",
                             n, dec_pc, dec_instr, dec_pc_next, hpc, mem[hpc], ADDR_W'(hpc + 16'd1));
                end
            end
            if (redir) begin
                q_pc.delete();
                q_t.delete();
                nxt_issue = branch_addr;
            end else begin
                if (exp_valid && dec_ready) begin
                    void'(q_pc.pop_front());
                    void'(q_t.pop_front());
                end
                if (exp_en) begin
                    q_pc.push_back(nxt_issue);
                    q_t.push_back(now);
                    nxt_issue = nxt_issue + 16'd1;
                end
            end
            now++;
            @(negedge clk);
        end
        branch = 1'b0;
        dec_ready = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = INSTR_W'(32'h1000 + i);
        test_reset();
        test_stream();
        test_backpressure();
        test_branch_arm();
        test_halt();
        test_wrap();
        test_reset_midflight();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not complete, got timeout exp finish");
        $fatal(1);
    end

endmodule
